// File: rtl/axilite_pkg.sv
// Shared types and constants for the AXI-Lite master slice:
// FSM state encoding, response codes and default bus widths.
package axilite_pkg;

    localparam int AXIL_ADDR_W = 32;
    localparam int AXIL_DATA_W = 32;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        DONE
    } axil_mst_state_t;

endpackage

// File: rtl/axilite_int.sv
// AXI-Lite channel bundle (AW/W/B/AR/R) with master and slave views.
// Clock and reset travel separately.
interface axilite_int #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              AXI_AWVALID;
    logic              AXI_AWREADY;
    logic [ADDR_W-1:0] AXI_AWADDR;
    logic              AXI_WVALID;
    logic              AXI_WREADY;
    logic [DATA_W-1:0] AXI_WDATA;
    logic [DATA_W/8-1:0] AXI_WSTRB;
    logic              AXI_BVALID;
    logic              AXI_BREADY;
    logic [1:0]        AXI_BRESP;
    logic              AXI_ARVALID;
    logic              AXI_ARREADY;
    logic [ADDR_W-1:0] AXI_ARADDR;
    logic              AXI_RVALID;
    logic              AXI_RREADY;
    logic [DATA_W-1:0] AXI_RDATA;
    logic [1:0]        AXI_RRESP;

    modport master (
        output AXI_AWVALID, AXI_AWADDR, AXI_WVALID, AXI_WDATA,
        output AXI_WSTRB, AXI_BREADY, AXI_ARVALID, AXI_ARADDR,
        output AXI_RREADY,
        input  AXI_AWREADY, AXI_WREADY, AXI_BVALID, AXI_BRESP,
        input  AXI_ARREADY, AXI_RVALID, AXI_RDATA, AXI_RRESP
    );

    modport slave (
        input  AXI_AWVALID, AXI_AWADDR, AXI_WVALID, AXI_WDATA,
        input  AXI_WSTRB, AXI_BREADY, AXI_ARVALID, AXI_ARADDR,
        input  AXI_RREADY,
        output AXI_AWREADY, AXI_WREADY, AXI_BVALID, AXI_BRESP,
        output AXI_ARREADY, AXI_RVALID, AXI_RDATA, AXI_RRESP
    );
endinterface

// File: rtl/axilite_master_stats.sv
// Completion counters for axilite_master; only instantiated when
// AXILITE_MASTER_STATS_EN is defined. Counters wrap freely.
module axilite_master_stats (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_done,
    input  logic        rd_done,
    input  logic        err,
    output logic [15:0] stat_wr_cnt,
    output logic [15:0] stat_rd_cnt,
    output logic [7:0]  stat_err_cnt
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_wr_cnt  <= '0;
            stat_rd_cnt  <= '0;
            stat_err_cnt <= '0;
        end else begin
            if (wr_done)
                stat_wr_cnt <= stat_wr_cnt + 16'd1;
            if (rd_done)
                stat_rd_cnt <= stat_rd_cnt + 16'd1;
            if (err)
                stat_err_cnt <= stat_err_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/axilite_master.sv
// Single-outstanding AXI-Lite initiator driven by a local cmd/rsp port.
// Optional completion counters: define AXILITE_MASTER_STATS_EN.
module axilite_master
    import axilite_pkg::*;
#(
    parameter int ADDR_W = AXIL_ADDR_W,
    parameter int DATA_W = AXIL_DATA_W
) (
    input  logic              AXI_ACLK,
    input  logic              AXI_ARESETN,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
`ifdef AXILITE_MASTER_STATS_EN
    output logic [15:0]       stat_wr_cnt,
    output logic [15:0]       stat_rd_cnt,
    output logic [7:0]        stat_err_cnt,
`endif
    axilite_int.master        io
);

    axil_mst_state_t   state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        resp_q, resp_d;
    logic              awv_q, awv_d;
    logic              wv_q, wv_d;
    logic              arv_q, arv_d;
    logic              bready_q, bready_d;
    logic              rready_q, rready_d;
    logic              rsp_valid_q, rsp_valid_d;

    always_ff @(posedge AXI_ACLK) begin
        if (!AXI_ARESETN) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            resp_q      <= '0;
            awv_q       <= 1'b0;
            wv_q        <= 1'b0;
            arv_q       <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
            awv_q       <= awv_d;
            wv_q        <= wv_d;
            arv_q       <= arv_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        resp_d      = resp_q;
        awv_d       = awv_q;
        wv_d        = wv_q;
        arv_d       = arv_q;
        bready_d    = bready_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_write ? cmd_wdata : '0;
                    awv_d   = cmd_write;
                    wv_d    = cmd_write;
                    arv_d   = !cmd_write;
                    state_d = cmd_write ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                // AW and W retire independently; a retired one stays low
                awv_d = awv_q && !io.AXI_AWREADY;
                wv_d  = wv_q && !io.AXI_WREADY;
                if (!awv_d && !wv_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (io.AXI_BVALID) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    resp_d      = io.AXI_BRESP;
                    rdata_d     = '0;
                    state_d     = DONE;
                end
            end
            RD_REQ: begin
                if (io.AXI_ARREADY) begin
                    arv_d    = 1'b0;
                    rready_d = 1'b1;
                    state_d  = RD_RESP;
                end
            end
            RD_RESP: begin
                if (io.AXI_RVALID) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    resp_d      = io.AXI_RRESP;
                    rdata_d     = io.AXI_RDATA;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready      = (state_q == IDLE);
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rdata_q;
    assign rsp_resp       = resp_q;
    assign io.AXI_AWVALID = awv_q;
    assign io.AXI_AWADDR  = addr_q;
    assign io.AXI_WVALID  = wv_q;
    assign io.AXI_WDATA   = wdata_q;
    assign io.AXI_WSTRB   = '1;
    assign io.AXI_BREADY  = bready_q;
    assign io.AXI_ARVALID = arv_q;
    assign io.AXI_ARADDR  = addr_q;
    assign io.AXI_RREADY  = rready_q;

`ifdef AXILITE_MASTER_STATS_EN
    logic       wr_done;
    logic       rd_done;
    logic [1:0] resp_in;

    assign wr_done = (state_q == WR_RESP) && io.AXI_BVALID;
    assign rd_done = (state_q == RD_RESP) && io.AXI_RVALID;
    assign resp_in = wr_done ? io.AXI_BRESP : io.AXI_RRESP;

    axilite_master_stats u_stats (
        .clk          (AXI_ACLK),
        .rst_n        (AXI_ARESETN),
        .wr_done      (wr_done),
        .rd_done      (rd_done),
        .err          ((wr_done || rd_done) && (resp_in != AXI_RESP_OKAY)),
        .stat_wr_cnt  (stat_wr_cnt),
        .stat_rd_cnt  (stat_rd_cnt),
        .stat_err_cnt (stat_err_cnt)
    );
`endif

endmodule
